// File: rtl/axi_single_master.sv
// Single-beat AXI4 initiator bridge for a core memory port.
// Converts one core request into one AXI read or write and stalls the core until it completes.
module axi_single_master #(
    parameter logic [3:0] MASTER_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [3:0]  ARID_M,
    output logic [31:0] ARADDR_M,
    output logic [3:0]  ARLEN_M,
    output logic [2:0]  ARSIZE_M,
    output logic [1:0]  ARBURST_M,
    output logic        ARVALID_M,
    input  logic        ARREADY_M,
    input  logic [3:0]  RID_M,
    input  logic [31:0] RDATA_M,
    input  logic [1:0]  RRESP_M,
    input  logic        RLAST_M,
    input  logic        RVALID_M,
    output logic        RREADY_M,
    output logic [3:0]  AWID_M,
    output logic [31:0] AWADDR_M,
    output logic [3:0]  AWLEN_M,
    output logic [2:0]  AWSIZE_M,
    output logic [1:0]  AWBURST_M,
    output logic        AWVALID_M,
    input  logic        AWREADY_M,
    output logic [31:0] WDATA_M,
    output logic [3:0]  WSTRB_M,
    output logic        WLAST_M,
    output logic        WVALID_M,
    input  logic        WREADY_M,
    input  logic [3:0]  BID_M,
    input  logic [1:0]  BRESP_M,
    input  logic        BVALID_M,
    output logic        BREADY_M
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] AR   = 3'd1;
    localparam logic [2:0] R    = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] B    = 3'd4;
    localparam logic [2:0] RESP = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        aw_done;
    logic        w_done;
    logic        aw_ok;
    logic        w_ok;
    logic        unused_ok;

    // ID, last and response-ID are not needed for single-beat, single-ID traffic
    assign unused_ok = ^{RID_M, RLAST_M, BID_M};

    assign aw_ok = aw_done | AWREADY_M;
    assign w_ok  = w_done | WREADY_M;

    assign ARID_M    = MASTER_ID;
    assign ARLEN_M   = 4'd0;
    assign ARSIZE_M  = 3'b010;
    assign ARBURST_M = 2'b01;
    assign ARADDR_M  = addr_q;
    assign ARVALID_M = (state == AR);
    assign RREADY_M  = (state == R);

    assign AWID_M    = MASTER_ID;
    assign AWLEN_M   = 4'd0;
    assign AWSIZE_M  = 3'b010;
    assign AWBURST_M = 2'b01;
    assign AWADDR_M  = addr_q;
    assign AWVALID_M = (state == WR) && !aw_done;
    assign WDATA_M   = wdata_q;
    assign WSTRB_M   = wstrb_q;
    assign WVALID_M  = (state == WR) && !w_done;
    assign WLAST_M   = WVALID_M;
    assign BREADY_M  = (state == B);

    assign done_o  = (state == RESP);
    assign err_o   = (state == RESP) && err_q;
    assign rdata_o = rdata_q;
    assign stall_o = (state == IDLE) ? req_i : (state != RESP);

    // Next-state selection for the transaction sequencer
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (req_i) state_d = we_i ? WR : AR;
            AR:      if (ARREADY_M) state_d = R;
            R:       if (RVALID_M) state_d = RESP;
            WR:      if (aw_ok && w_ok) state_d = B;
            B:       if (BVALID_M) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request capture, handshake tracking and response capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && req_i) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                wstrb_q <= wstrb_i;
            end
            if (state == WR) begin
                if (aw_ok && w_ok) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    if (AWREADY_M) aw_done <= 1'b1;
                    if (WREADY_M)  w_done  <= 1'b1;
                end
            end
            if (state == R && RVALID_M) begin
                rdata_q <= RDATA_M;
                err_q   <= (RRESP_M != 2'b00);
            end
            if (state == B && BVALID_M) begin
                err_q <= (BRESP_M != 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_axi_single_master.sv
// Directed bench for axi_single_master.
// Table of transactions with a delay-programmable slave, plus reset and back-to-back sequences.
module tb_axi_single_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_i, we_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  wstrb_i;
    logic        stall_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic [3:0]  ARID_M, ARLEN_M, AWID_M, AWLEN_M;
    logic [31:0] ARADDR_M, AWADDR_M, WDATA_M;
    logic [2:0]  ARSIZE_M, AWSIZE_M;
    logic [1:0]  ARBURST_M, AWBURST_M;
    logic        ARVALID_M, ARREADY_M, AWVALID_M, AWREADY_M;
    logic [3:0]  RID_M, BID_M, WSTRB_M;
    logic [31:0] RDATA_M;
    logic [1:0]  RRESP_M, BRESP_M;
    logic        RLAST_M, RVALID_M, RREADY_M;
    logic        WLAST_M, WVALID_M, WREADY_M;
    logic        BVALID_M, BREADY_M;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    axi_single_master dut (
        .clk(clk), .rstn(rstn),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .stall_o(stall_o), .done_o(done_o),
        .rdata_o(rdata_o), .err_o(err_o),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M),
        .ARSIZE_M(ARSIZE_M), .ARBURST_M(ARBURST_M),
        .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M),
        .RLAST_M(RLAST_M), .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M),
        .AWSIZE_M(AWSIZE_M), .AWBURST_M(AWBURST_M),
        .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M),
        .WVALID_M(WVALID_M), .WREADY_M(WREADY_M),
        .BID_M(BID_M), .BRESP_M(BRESP_M),
        .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ar_d;
        int          r_d;
        int          aw_d;
        int          w_d;
        int          b_d;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[8];
    vec_t post_rst;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clear_slave();
        ARREADY_M = 0; RVALID_M = 0; RDATA_M = 0; RRESP_M = 0;
        RLAST_M = 0; RID_M = 0; AWREADY_M = 0; WREADY_M = 0;
        BVALID_M = 0; BRESP_M = 0; BID_M = 0;
    endtask

    task automatic fast_slave();
        ARREADY_M = ARVALID_M;
        RVALID_M  = RREADY_M;
        RDATA_M   = 32'hCAFE0001;
        RLAST_M   = RREADY_M;
        AWREADY_M = AWVALID_M;
        WREADY_M  = WVALID_M;
        BVALID_M  = BREADY_M;
    endtask

    task automatic step();
        @(negedge clk);
        clear_slave();
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        int arn, rn, awn, wn, bn, lat;
        bit aw_hs, w_hs, bad;
        logic got_err;
        logic [31:0] got_rd;
        arn = 0; rn = 0; awn = 0; wn = 0; bn = 0;
        lat = -1; aw_hs = 0; w_hs = 0; bad = 0;
        got_err = 1'bx; got_rd = 'x;
        @(negedge clk);
        req_i = 1; we_i = v.we; addr_i = v.addr;
        wdata_i = v.wdata; wstrb_i = v.wstrb;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            req_i = 0;
            clear_slave();
            if (done_o) begin
                lat = c; got_err = err_o; got_rd = rdata_o;
                break;
            end
            if (!stall_o) bad = 1;
            if (v.we ? (ARVALID_M || RREADY_M)
                     : (AWVALID_M || WVALID_M || BREADY_M)) bad = 1;
            if (ARVALID_M) begin
                if (ARADDR_M !== v.addr || ARLEN_M !== 4'd0 ||
                    ARSIZE_M !== 3'b010 || ARBURST_M !== 2'b01 ||
                    ARID_M !== 4'd0) bad = 1;
                ARREADY_M = (arn >= v.ar_d);
                arn++;
            end
            if (RREADY_M) begin
                RVALID_M = (rn >= v.r_d);
                RDATA_M = v.rdata;
                RRESP_M = v.resp;
                RLAST_M = 1;
                rn++;
            end
            if (AWVALID_M) begin
                if (aw_hs || AWADDR_M !== v.addr || AWLEN_M !== 4'd0 ||
                    AWSIZE_M !== 3'b010 || AWBURST_M !== 2'b01 ||
                    AWID_M !== 4'd0) bad = 1;
                AWREADY_M = (awn >= v.aw_d);
                aw_hs = AWREADY_M;
                awn++;
            end
            if (WVALID_M) begin
                if (w_hs || WDATA_M !== v.wdata || WSTRB_M !== v.wstrb ||
                    WLAST_M !== 1'b1) bad = 1;
                WREADY_M = (wn >= v.w_d);
                w_hs = WREADY_M;
                wn++;
            end
            if (BREADY_M) begin
                if (!(aw_hs && w_hs)) bad = 1;
                BVALID_M = (bn >= v.b_d);
                BRESP_M = v.resp;
                bn++;
            end
        end
        check({tag, "_lat"}, lat, v.exp_lat);
        check({tag, "_err"}, got_err, v.exp_err);
        check({tag, "_rdata"}, got_rd, v.exp_rdata);
        check({tag, "_proto"}, bad, 0);
        @(negedge clk);
        check({tag, "_pulse"}, {done_o, stall_o, err_o}, 3'b000);
    endtask

    initial begin
        // we addr wdata wstrb ar r aw w b resp rdata exp_rdata exp_err lat
        tbl[0] = '{0, 32'h0000_1004, 0, 0, 0, 1, 0, 0, 0, 2'b00,
                   32'hDEADBEEF, 32'hDEADBEEF, 0, 3};
        tbl[1] = '{1, 32'h0000_2000, 32'h12345678, 4'hC, 0, 0, 2, 0, 0,
                   2'b00, 0, 32'hDEADBEEF, 0, 4};
        tbl[2] = '{0, 32'hFFFF_0000, 0, 0, 0, 0, 0, 0, 0, 2'b11,
                   0, 0, 1, 2};
        tbl[3] = '{1, 32'h0000_3000, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0, 1,
                   2'b11, 0, 0, 1, 3};
        tbl[4] = '{1, 32'h0000_3004, 32'h55667788, 4'h3, 0, 0, 0, 3, 0,
                   2'b10, 0, 0, 1, 5};
        tbl[5] = '{0, 32'h0000_4000, 0, 0, 3, 2, 0, 0, 0, 2'b10,
                   32'hA5A5A5A5, 32'hA5A5A5A5, 1, 7};
        tbl[6] = '{0, 32'h0000_0040, 0, 0, 0, 0, 0, 0, 0, 2'b00,
                   32'h01234567, 32'h01234567, 0, 2};
        tbl[7] = '{0, 32'h0000_5000, 0, 0, 10, 0, 0, 0, 0, 2'b00,
                   32'h0BADF00D, 32'h0BADF00D, 0, 12};
        post_rst = '{0, 32'h0000_9000, 0, 0, 0, 0, 0, 0, 0, 2'b00,
                     32'h13579BDF, 32'h13579BDF, 0, 2};

        rstn = 0; req_i = 0; we_i = 0; addr_i = 0;
        wdata_i = 0; wstrb_i = 0;
        clear_slave();
        #12;
        check("rst_ctl", {ARVALID_M, RREADY_M, AWVALID_M, WVALID_M,
                          BREADY_M, done_o, err_o, WLAST_M, stall_o}, 0);
        check("rst_data", {ARADDR_M, AWADDR_M, WDATA_M, WSTRB_M, rdata_o}, 0);
        req_i = 1;
        #1;
        check("stall_idle_req", stall_o, 1);
        req_i = 0;
        #1;
        check("stall_idle_noreq", stall_o, 0);
        @(negedge clk);
        rstn = 1;

        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset while waiting for the write response
        begin
            bit reached;
            reached = 0;
            @(negedge clk);
            req_i = 1; we_i = 1; addr_i = 32'h0000_6000;
            wdata_i = 32'hFEEDFACE; wstrb_i = 4'hF;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                req_i = 0;
                clear_slave();
                if (BREADY_M) begin
                    reached = 1;
                    break;
                end
                AWREADY_M = AWVALID_M;
                WREADY_M = WVALID_M;
            end
            check("midrst_reach_b", reached, 1);
            #2 rstn = 0;
            #1;
            check("midrst_ctl", {ARVALID_M, RREADY_M, AWVALID_M, WVALID_M,
                                 BREADY_M, done_o, err_o}, 0);
            check("midrst_data", {AWADDR_M, WDATA_M, WSTRB_M}, 0);
            @(negedge clk);
            rstn = 1;
        end
        run_txn("postrst", post_rst);

        // Read then write with the request held high across RESP
        @(negedge clk);
        req_i = 1; we_i = 0; addr_i = 32'h0000_7000;
        step();
        check("b2b_ar", ARVALID_M, 1);
        we_i = 1; addr_i = 32'h0000_8000;
        wdata_i = 32'h0F0F0F0F; wstrb_i = 4'h1;
        fast_slave();
        step();
        check("b2b_r", RREADY_M, 1);
        fast_slave();
        step();
        check("b2b_resp", {done_o, stall_o}, 2'b10);
        fast_slave();
        step();
        check("b2b_idle", {stall_o, ARVALID_M, AWVALID_M, done_o}, 4'b1000);
        fast_slave();
        step();
        check("b2b_aw", {AWVALID_M, WVALID_M, AWADDR_M}, {2'b11, 32'h0000_8000});
        req_i = 0;
        fast_slave();
        step();
        check("b2b_b", BREADY_M, 1);
        fast_slave();
        step();
        check("b2b_done", {done_o, err_o, rdata_o}, {2'b10, 32'hCAFE0001});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/axi_single_master.md
# axi_single_master

Initiator-side AXI4 bridge that turns a core's single-request memory port (instruction or data) into single-beat AXI4 read or write transactions toward the interconnect. It sits between the CPU and the AXI crossbar, which routes to the SRAM wrappers or to the decode-error default slave. It stalls the core until the transaction completes, returns read data, and flags SLVERR/DECERR responses as errors.

## Interface
- MASTER_ID, default 4'd0: constant driven on ARID_M/AWID_M.
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req_i  in  1  core request; sampled only in IDLE.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address, forwarded unmodified.
- wdata_i  in  32  write data.
- wstrb_i  in  4  byte enables, active-high.
- stall_o  out  1  core must hold its request while high.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  last read data, held until the next read completes.
- err_o  out  1  valid with done_o; 1 if RRESP/BRESP != OKAY.
- ARID_M/ARADDR_M/ARLEN_M/ARSIZE_M/ARBURST_M/ARVALID_M  out  4/32/4/3/2/1, ARREADY_M  in  1: AXI read address.
- RID_M  in  4, RDATA_M  in  32, RRESP_M  in  2, RLAST_M  in  1, RVALID_M  in  1, RREADY_M  out  1: AXI read data.
- AWID_M/AWADDR_M/AWLEN_M/AWSIZE_M/AWBURST_M/AWVALID_M  out  4/32/4/3/2/1, AWREADY_M  in  1: AXI write address.
- WDATA_M  out  32, WSTRB_M  out  4, WLAST_M  out  1, WVALID_M  out  1, WREADY_M  in  1: AXI write data.
- BID_M  in  4, BRESP_M  in  2, BVALID_M  in  1, BREADY_M  out  1: AXI write response.

## Operation
- Constant fields: ARLEN/AWLEN = 0, ARSIZE/AWSIZE = 3'b010, ARBURST/AWBURST = 2'b01 (INCR), WLAST_M = 1 whenever WVALID_M is high.
- States: IDLE, AR, R, WR, B, RESP.
- IDLE: if req_i is high, latch addr_i/wdata_i/wstrb_i/we_i and go to WR if we_i, else AR. Otherwise stay in IDLE.
- AR: ARVALID_M = 1. Go to R on ARREADY_M.
- R: RREADY_M = 1. On RVALID_M, capture RDATA_M into rdata_o, set err = (RRESP_M != 2'b00), and go to RESP. RLAST_M and RID_M are ignored.
- WR: AWVALID_M and WVALID_M both assert on WR entry.
  - Each channel drops independently after its own handshake, tracked by the aw_done and w_done flags.
  - Go to B in the cycle in which both channels have completed. Simultaneous handshakes in one cycle are legal.
  - W may complete before AW and vice versa.
- B: BREADY_M = 1. On BVALID_M, set err = (BRESP_M != 2'b00) and go to RESP. BID_M is ignored.
- RESP: done_o = 1, err_o = err, stall_o = 0. Always return to IDLE; no request is accepted in RESP.
- stall_o = req_i in IDLE, 1 in AR/R/WR/B, 0 in RESP.
- ARVALID/AWVALID/WVALID never drop before their handshake (AXI rule). Address and data outputs are stable while their VALID is high.
- A write never updates rdata_o.

## Timing
- Reset, asynchronous:
  - State = IDLE.
  - All VALID/READY outputs = 0; done_o = 0; err_o = 0.
  - rdata_o = 0; ARADDR/AWADDR/WDATA = 0; WSTRB = 0; aw_done = w_done = 0.
  - Reset mid-transaction abandons the transaction immediately.
- Minimum read latency, with ARREADY and RVALID asserted as early as possible:
  - req at cycle t.
  - ARVALID at t+1.
  - RREADY at t+2, with the RVALID handshake at t+2.
  - done_o at t+3.
- Minimum write latency:
  - req at cycle t.
  - AWVALID and WVALID at t+1, with both handshakes at t+1.
  - BREADY at t+2.
  - done_o at t+3.
- Back-to-back requests: the earliest acceptance of the next request is the IDLE cycle after RESP, i.e. a 4-cycle minimum period.
- No combinational path from AXI inputs to AXI outputs. stall_o depends combinationally on req_i only.

## Test plan
- Read OK: req_i=1, we_i=0, addr_i=0x0000_1004; slave ARREADY at 1st cycle, RVALID 2 cycles later with RDATA=0xDEADBEEF, RRESP=00 -> ARADDR_M=0x0000_1004, ARLEN=0, ARSIZE=010; done_o 1 cycle after RVALID; rdata_o=0xDEADBEEF; err_o=0.
- Write with skew: wdata=0x12345678, wstrb=0xC, addr=0x0000_2000; WREADY at cycle 1, AWREADY at cycle 3 -> WVALID drops after cycle 1, AWVALID drops after cycle 3, BREADY from cycle 4; BRESP=00 -> done_o, err_o=0; rdata_o unchanged.
- Decode error: read to 0xFFFF_0000 answered with RRESP=2'b11, RDATA=0 -> err_o=1 with done_o; write answered with BRESP=2'b11 -> err_o=1.
- Backpressure: ARREADY held low 10 cycles -> ARVALID_M and ARADDR_M stable throughout; stall_o=1 throughout.
- Reset mid-write: assert rstn=0 while in B -> all VALID/READY and done_o drop asynchronously; after release, a new read completes normally.
- Back-to-back: a read followed immediately by a write with req_i held -> the second request is accepted in the IDLE cycle after RESP, and AWVALID asserts 1 cycle later.
